// File: rtl/demo_bb_pkg.sv
// demo_bb_pkg
// Shared definitions for the demo bus responder: FSM state encoding,
// read/write mode constants and the wait-counter load helper.
// Ports: none (package).

package demo_bb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int WAIT_CNT_WIDTH = 4;

  // WAIT lasts wait_cycles cycles, counting down to zero, so the counter
  // starts one below the requested delay. A zero delay never enters WAIT.
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load(input int wait_cycles);
    return (wait_cycles > 0) ? WAIT_CNT_WIDTH'(wait_cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/demo_resp_mem.sv
// demo_resp_mem
// Single-port synchronous RAM with a registered read port and no reset.
// A read issued on one edge is visible on rdata after that edge and holds
// until the next read.
// Ports:
//   clk   - rising-edge clock
//   en    - access enable
//   we    - 1 = write wdata at addr, 0 = read addr into rdata
//   addr  - word index
//   wdata - write data
//   rdata - registered read data

module demo_resp_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/demo_bb_responder.sv
// demo_bb_responder
// Slow bus slave emulator: accepts one request at a time, accesses a small
// local memory, waits WAIT_CYCLES extra cycles and answers with a one-cycle
// rsp_ready pulse. Completed writes and reads are counted.
// Optional feature (macro DEMO_BB_RESP_ADDR_CHECK_EN): requests outside the
// BASE_ADDR window skip the memory and answer with rsp_err.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   req_valid, req_rw_mode - request strobe, 1 = write / 0 = read
//   req_addr, req_wdata    - request address and write data
//   rsp_rdata              - registered read data, held until the next read
//   rsp_ready, rsp_err     - one-cycle response and error pulses
//   busy                   - high whenever not IDLE
//   wr_count, rd_count     - wrapping counts of completed writes / reads

module demo_bb_responder
  import demo_bb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_ADDR_WIDTH = 5,
  parameter int                    WAIT_CYCLES    = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 16'h4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_rw_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_ready,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [7:0]            wr_count,
  output logic [7:0]            rd_count
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_e                      state_q, state_d;
  logic                        rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [WAIT_CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [7:0]                  wr_count_q, wr_count_d;
  logic [7:0]                  rd_count_q, rd_count_d;

  logic                        addr_ok;
  logic                        resp_enter;
  logic                        mem_en;
  logic                        mem_we;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]       mem_rdata;

`ifdef DEMO_BB_RESP_ADDR_CHECK_EN
  assign addr_ok = (addr_q[ADDR_WIDTH-1:MEM_ADDR_WIDTH] ==
                    BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH]);
  assign rsp_err = (state_q == RESP) && !addr_ok;
`else
  logic unused_upper;
  assign unused_upper = ^{addr_q[ADDR_WIDTH-1:MEM_ADDR_WIDTH], BASE_ADDR};
  assign addr_ok      = 1'b1;
  assign rsp_err      = 1'b0;
`endif

  // The RAM read is issued on the accepting edge straight from req_addr, so
  // the word is already on mem_rdata during ACCESS and can be registered into
  // rsp_rdata at the end of that cycle. Writes happen at the end of ACCESS.
  always_comb begin
    mem_en   = ((state_q == IDLE) && req_valid) ||
               ((state_q == ACCESS) && (rw_q == RW_WRITE) && addr_ok);
    mem_we   = (state_q == ACCESS) && (rw_q == RW_WRITE);
    mem_addr = (state_q == ACCESS) ? addr_q[MEM_ADDR_WIDTH-1:0]
                                   : req_addr[MEM_ADDR_WIDTH-1:0];
  end

  demo_resp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    resp_enter = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw_mode;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if ((rw_q == RW_READ) && addr_ok) begin
          rdata_d = mem_rdata;
        end
        if (WAIT_CYCLES > 0) begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = WAIT;
        end else begin
          state_d    = RESP;
          resp_enter = 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d    = RESP;
          resp_enter = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counters step on entry to RESP so the new value is visible alongside
    // the rsp_ready pulse of the access it counts.
    if (resp_enter && addr_ok) begin
      if (rw_q == RW_WRITE) begin
        wr_count_d = wr_count_q + 8'd1;
      end else begin
        rd_count_d = rd_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rw_q       <= RW_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rsp_ready = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_demo_bb_responder.sv
// tb_demo_bb_responder
// Bench for demo_bb_responder. Instance 0 uses the default delay and is
// tracked every cycle by a transaction-level model; instances 1 and 2 use
// delays of 0 and 15 cycles for latency checks.
// Honours DEMO_BB_RESP_ADDR_CHECK_EN when defined.

module tb_demo_bb_responder;

  localparam int          W_MAIN = 2;
  localparam logic [15:0] BASE   = 16'h4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic        req_valid   [3];
  logic        req_rw      [3];
  logic [15:0] req_addr    [3];
  logic [7:0]  req_wdata   [3];
  logic [7:0]  rsp_rdata   [3];
  logic        rsp_ready   [3];
  logic        rsp_err     [3];
  logic        busy        [3];
  logic [7:0]  wr_count    [3];
  logic [7:0]  rd_count    [3];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  demo_bb_responder #(.WAIT_CYCLES(W_MAIN)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_rw_mode(req_rw[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_ready(rsp_ready[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
    .wr_count(wr_count[0]), .rd_count(rd_count[0]));

  demo_bb_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_rw_mode(req_rw[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_ready(rsp_ready[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
    .wr_count(wr_count[1]), .rd_count(rd_count[1]));

  demo_bb_responder #(.WAIT_CYCLES(15)) u_dut_w15 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_rw_mode(req_rw[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_ready(rsp_ready[2]), .rsp_err(rsp_err[2]), .busy(busy[2]),
    .wr_count(wr_count[2]), .rd_count(rd_count[2]));

  // ---------------------------------------------------------------------
  // Transaction-level model of instance 0. A request accepted at edge A is
  // accessed at edge A+1, answered in the cycle following edge A+1+W, and
  // the responder is free again after edge A+2+W.
  // ---------------------------------------------------------------------
  int          cyc      = 0;
  bit          started  = 1'b0;
  bit          m_active = 1'b0;
  int          m_acc    = 0;
  logic        m_rw     = 1'b0;
  logic [15:0] m_addr   = '0;
  logic [7:0]  m_wdata  = '0;
  bit          m_ok     = 1'b1;
  logic [7:0]  m_mem    [32];
  logic [7:0]  m_rdata  = '0;
  logic [7:0]  m_wr     = '0;
  logic [7:0]  m_rd     = '0;

  function automatic bit addrOk(input logic [15:0] a);
`ifdef DEMO_BB_RESP_ADDR_CHECK_EN
    return (a[15:5] == BASE[15:5]);
`else
    return (a != 16'hFFFF) || (a == 16'hFFFF);
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      started = 1'b1;
      if (rst) begin
        m_active = 1'b0;
        m_rdata  = '0;
        m_wr     = '0;
        m_rd     = '0;
      end else begin
        if (m_active && (cyc == m_acc + 1) && m_ok) begin
          if (m_rw) m_mem[m_addr[4:0]] = m_wdata;
          else      m_rdata = m_mem[m_addr[4:0]];
        end
        if (m_active && (cyc == m_acc + 1 + W_MAIN) && m_ok) begin
          if (m_rw) m_wr = m_wr + 8'd1;
          else      m_rd = m_rd + 8'd1;
        end
        if (m_active && (cyc == m_acc + 2 + W_MAIN)) begin
          m_active = 1'b0;
        end else if (!m_active && req_valid[0]) begin
          m_active = 1'b1;
          m_acc    = cyc;
          m_rw     = req_rw[0];
          m_addr   = req_addr[0];
          m_wdata  = req_wdata[0];
          m_ok     = addrOk(req_addr[0]);
        end
      end
    end
  end

  // Every-cycle comparison of instance 0 against the model.
  initial begin
    logic exp_ready;
    logic exp_err;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_ready = m_active && (cyc == m_acc + 1 + W_MAIN);
        exp_err   = exp_ready && !m_ok;
        checks++;
        if ((rsp_ready[0] === exp_ready) && (rsp_err[0] === exp_err) &&
            (busy[0] === m_active) && (rsp_rdata[0] === m_rdata) &&
            (wr_count[0] === m_wr) && (rd_count[0] === m_rd)) begin
          passed++;
        end else begin
          $display("[TB] FAIL cycle_%0d_outputs: got ready=%0b err=%0b busy=%0b rdata=%02h wr=%0d rd=%0d, expected ready=%0b err=%0b busy=%0b rdata=%02h wr=%0d rd=%0d",
                   cyc, rsp_ready[0], rsp_err[0], busy[0], rsp_rdata[0], wr_count[0], rd_count[0],
                   exp_ready, exp_err, m_active, m_rdata, m_wr, m_rd);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Presents one request to instance sel for exactly one rising edge.
  task automatic applyStimulus(input int sel, input logic rw, input logic [15:0] addr,
                               input logic [7:0] wdata);
    @(negedge clk);
    req_valid[sel] = 1'b1;
    req_rw[sel]    = rw;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    @(posedge clk);
  endtask

  // Latency counts rising edges from the accepting edge to the edge that
  // samples rsp_ready high. Returns in the middle of the response cycle.
  task automatic doTransaction(input int sel, input logic rw, input logic [15:0] addr,
                               input logic [7:0] wdata, output int lat,
                               output logic [7:0] rdata, output logic err);
    bit found;
    found = 1'b0;
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    applyStimulus(sel, rw, addr, wdata);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (i == 0) req_valid[sel] = 1'b0;
      if (rsp_ready[sel]) begin
        found = 1'b1;
        lat   = i + 1;
        rdata = rsp_rdata[sel];
        err   = rsp_err[sel];
      end
    end
    if (!found) checkOutput("response_timeout", 0, 1);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int         lat;
    logic [7:0] rd;
    logic       er;
    int         pulses;
    logic [7:0] wr_before;

    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_rw[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy[0], 0);
    checkOutput("reset_ready", rsp_ready[0], 0);
    checkOutput("reset_rdata", rsp_rdata[0], 0);
    checkOutput("reset_wr_count", wr_count[0], 0);
    checkOutput("reset_rd_count", rd_count[0], 0);
    #2 rst = 1'b0;

    $display("[TB] write then read back");
    doTransaction(0, 1'b1, 16'h4001, 8'hA5, lat, rd, er);
    checkOutput("latency_w2_write", lat, 4);
    doTransaction(0, 1'b0, 16'h4001, 8'h00, lat, rd, er);
    checkOutput("latency_w2_read", lat, 4);
    checkOutput("read_4001", rd, 8'hA5);
    checkOutput("wr_count_after_rw", wr_count[0], 1);
    checkOutput("rd_count_after_rw", rd_count[0], 1);

    doTransaction(0, 1'b1, 16'h4002, 8'h5A, lat, rd, er);
    checkOutput("rdata_held_over_write", rd, 8'hA5);
    doTransaction(0, 1'b1, 16'h4001, 8'h3C, lat, rd, er);
    doTransaction(0, 1'b0, 16'h4001, 8'h00, lat, rd, er);
    checkOutput("read_after_rewrite", rd, 8'h3C);

`ifdef DEMO_BB_RESP_ADDR_CHECK_EN
    $display("[TB] out-of-window write");
    doTransaction(0, 1'b1, 16'h8001, 8'h77, lat, rd, er);
    checkOutput("oow_err", er, 1);
    checkOutput("oow_latency", lat, 4);
    checkOutput("oow_wr_count", wr_count[0], 3);
    doTransaction(0, 1'b0, 16'h4001, 8'h00, lat, rd, er);
    checkOutput("oow_mem_unchanged", rd, 8'h3C);
    checkOutput("oow_read_err", er, 0);
    checkOutput("oow_rd_count", rd_count[0], 3);
`else
    $display("[TB] upper address bits ignored");
    doTransaction(0, 1'b1, 16'h8003, 8'h66, lat, rd, er);
    checkOutput("alias_err", er, 0);
    checkOutput("alias_wr_count", wr_count[0], 4);
    doTransaction(0, 1'b0, 16'h4003, 8'h00, lat, rd, er);
    checkOutput("alias_read", rd, 8'h66);
    checkOutput("alias_rd_count", rd_count[0], 3);
`endif

    $display("[TB] latency extremes");
    doTransaction(1, 1'b1, 16'h4000, 8'h11, lat, rd, er);
    checkOutput("latency_w0", lat, 2);
    doTransaction(1, 1'b0, 16'h4000, 8'h00, lat, rd, er);
    checkOutput("latency_w0_read", lat, 2);
    checkOutput("read_w0", rd, 8'h11);
    doTransaction(2, 1'b1, 16'h4000, 8'h22, lat, rd, er);
    checkOutput("latency_w15", lat, 17);

    $display("[TB] req_valid held high");
    wr_before = wr_count[0];
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_rw[0]    = 1'b1;
    req_addr[0]  = 16'h4005;
    req_wdata[0] = 8'h99;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 4) req_valid[0] = 1'b0;
      if (rsp_ready[0]) pulses++;
    end
    checkOutput("held_valid_pulses", pulses, 1);
    checkOutput("held_valid_writes", wr_count[0] - wr_before, 1);

    $display("[TB] reset during wait");
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_rw[0]    = 1'b0;
    req_addr[0]  = 16'h4001;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_busy", busy[0], 0);
    checkOutput("midreset_ready", rsp_ready[0], 0);
    checkOutput("midreset_err", rsp_err[0], 0);
    checkOutput("midreset_rdata", rsp_rdata[0], 0);
    checkOutput("midreset_wr_count", wr_count[0], 0);
    checkOutput("midreset_rd_count", rd_count[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_ready[0]) pulses++;
    end
    checkOutput("midreset_no_response", pulses, 0);
    doTransaction(0, 1'b0, 16'h4001, 8'h00, lat, rd, er);
    checkOutput("postreset_latency", lat, 4);
    checkOutput("postreset_read", rd, 8'h3C);
    checkOutput("postreset_rd_count", rd_count[0], 1);

    $display("[TB] write counter wrap");
    for (int i = 0; i < 255; i++) begin
      doTransaction(0, 1'b1, 16'h4000 + 16'(i % 32), 8'(i), lat, rd, er);
    end
    checkOutput("wr_count_255", wr_count[0], 255);
    doTransaction(0, 1'b1, 16'h401F, 8'hFF, lat, rd, er);
    checkOutput("wr_count_wrap", wr_count[0], 0);
    doTransaction(0, 1'b0, 16'h401F, 8'h00, lat, rd, er);
    checkOutput("read_after_wrap", rd, 8'hFF);
    checkOutput("rd_count_after_wrap", rd_count[0], 2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
